// File: rtl/writeback_stage_pkg.sv
// Shared widths, link constants and result-source encoding for the MIPS writeback stage.
// Decode and hazard logic import the same link constants so every stage agrees on jal.
package writeback_stage_pkg;

    localparam int WB_DWIDTH      = 32;
    localparam int WB_AWIDTH      = 5;
    localparam int WB_PC_WIDTH    = 32;
    localparam int WB_LINK_OFFSET = 4;
    localparam int WB_LINK_REG    = 31;

    typedef enum logic [1:0] {
        SRC_ALU  = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_LINK = 2'd2
    } wb_src_e;

    // jal takes priority over memtoreg.
    function automatic wb_src_e select_src(input logic jal, input logic memtoreg);
        if (jal) begin
            return SRC_LINK;
        end
        if (memtoreg) begin
            return SRC_MEM;
        end
        return SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_result_mux.sv
// Combinational writeback result select (link / load / ALU) and write-enable qualification,
// including suppression of any write that would target $0.
module wb_result_mux
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH      = WB_DWIDTH,
    parameter int AWIDTH      = WB_AWIDTH,
    parameter int PC_WIDTH    = WB_PC_WIDTH,
    parameter int LINK_OFFSET = WB_LINK_OFFSET,
    parameter int LINK_REG    = WB_LINK_REG
) (
    input  logic                i_valid,
    input  logic                i_fresh,
    input  logic                i_reg_wr,
    input  logic                i_jal,
    input  logic                i_memtoreg,
    input  logic [DWIDTH-1:0]   i_alu_value,
    input  logic [DWIDTH-1:0]   i_mem_data,
    input  logic [PC_WIDTH-1:0] i_pc,
    input  logic [AWIDTH-1:0]   i_addr_rd,
    output logic                o_reg_wr,
    output logic [AWIDTH-1:0]   o_addr_rd,
    output logic [DWIDTH-1:0]   o_data_rd
);

    wb_src_e             w_src;
    logic [PC_WIDTH-1:0] w_link_pc;

    assign w_src     = select_src(i_jal, i_memtoreg);
    // The link address wraps modulo 2^PC_WIDTH before being resized to the data width.
    assign w_link_pc = i_pc + PC_WIDTH'(LINK_OFFSET);

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves o_data_rd unassigned (no latch).
        o_data_rd = i_alu_value;
        case (w_src)
            SRC_LINK: o_data_rd = DWIDTH'(w_link_pc);
            SRC_MEM:  o_data_rd = i_mem_data;
            default:  o_data_rd = i_alu_value;
        endcase
    end

    assign o_addr_rd = i_jal ? AWIDTH'(LINK_REG) : i_addr_rd;
    assign o_reg_wr  = i_valid & i_fresh & (i_reg_wr | i_jal) & (o_addr_rd != '0);

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, register-file write port driver, one-cycle bypass entry
// and retired-instruction counter for the MIPS core.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DWIDTH      = WB_DWIDTH,
    parameter int AWIDTH      = WB_AWIDTH,
    parameter int PC_WIDTH    = WB_PC_WIDTH,
    parameter int LINK_OFFSET = WB_LINK_OFFSET,
    parameter int LINK_REG    = WB_LINK_REG
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic                wb_i_ce,
    input  logic                wb_i_stall,
    input  logic                wb_i_flush,
    input  logic [DWIDTH-1:0]   wb_i_alu_value,
    input  logic [DWIDTH-1:0]   wb_i_mem_data,
    input  logic                wb_i_memtoreg,
    input  logic                wb_i_reg_wr,
    input  logic                wb_i_jal,
    input  logic [PC_WIDTH-1:0] wb_i_pc,
    input  logic [AWIDTH-1:0]   wb_i_addr_rd,
    output logic                wb_o_reg_wr,
    output logic [AWIDTH-1:0]   wb_o_addr_rd,
    output logic [DWIDTH-1:0]   wb_o_data_rd,
    output logic                wb_o_ce,
    output logic                wb_o_fwd_valid,
    output logic [AWIDTH-1:0]   wb_o_fwd_addr,
    output logic [DWIDTH-1:0]   wb_o_fwd_data,
    output logic [31:0]         wb_o_retired
);

    logic                r_valid;
    logic                r_fresh;
    logic [DWIDTH-1:0]   r_alu_value;
    logic [DWIDTH-1:0]   r_mem_data;
    logic                r_memtoreg;
    logic                r_reg_wr;
    logic                r_jal;
    logic [PC_WIDTH-1:0] r_pc;
    logic [AWIDTH-1:0]   r_addr_rd;
    logic                r_fwd_valid;
    logic [AWIDTH-1:0]   r_fwd_addr;
    logic [DWIDTH-1:0]   r_fwd_data;
    logic [31:0]         r_retired;

    logic                w_reg_wr;
    logic [AWIDTH-1:0]   w_addr_rd;
    logic [DWIDTH-1:0]   w_data_rd;

    // Flush outranks stall; a stalled entry loses its fresh bit so it writes and retires once.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            // NOTE: datapath fields are reset too, because every output must read 0 out of reset.
            r_valid     <= 1'b0;
            r_fresh     <= 1'b0;
            r_alu_value <= '0;
            r_mem_data  <= '0;
            r_memtoreg  <= 1'b0;
            r_reg_wr    <= 1'b0;
            r_jal       <= 1'b0;
            r_pc        <= '0;
            r_addr_rd   <= '0;
        end else if (wb_i_flush) begin
            r_valid <= 1'b0;
            r_fresh <= 1'b0;
        end else if (wb_i_stall) begin
            r_fresh <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_valid     <= wb_i_ce;
            r_fresh     <= wb_i_ce;
            r_alu_value <= wb_i_alu_value;
            r_mem_data  <= wb_i_mem_data;
            r_memtoreg  <= wb_i_memtoreg;
            r_reg_wr    <= wb_i_reg_wr;
            r_jal       <= wb_i_jal;
            r_pc        <= wb_i_pc;
            r_addr_rd   <= wb_i_addr_rd;
        end
    end

    wb_result_mux #(
        .DWIDTH     (DWIDTH),
        .AWIDTH     (AWIDTH),
        .PC_WIDTH   (PC_WIDTH),
        .LINK_OFFSET(LINK_OFFSET),
        .LINK_REG   (LINK_REG)
    ) u_result_mux (
        .i_valid    (r_valid),
        .i_fresh    (r_fresh),
        .i_reg_wr   (r_reg_wr),
        .i_jal      (r_jal),
        .i_memtoreg (r_memtoreg),
        .i_alu_value(r_alu_value),
        .i_mem_data (r_mem_data),
        .i_pc       (r_pc),
        .i_addr_rd  (r_addr_rd),
        .o_reg_wr   (w_reg_wr),
        .o_addr_rd  (w_addr_rd),
        .o_data_rd  (w_data_rd)
    );

    // Bypass mirrors the write being committed at this edge for exactly one cycle.
    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
        end else begin
            r_fwd_valid <= w_reg_wr;
            if (w_reg_wr) begin
                r_fwd_addr <= w_addr_rd;
                r_fwd_data <= w_data_rd;
            end
        end
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            r_retired <= '0;
        end else if (r_valid && r_fresh) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign wb_o_reg_wr    = w_reg_wr;
    assign wb_o_addr_rd   = w_addr_rd;
    assign wb_o_data_rd   = w_data_rd;
    assign wb_o_ce        = r_valid;
    assign wb_o_fwd_valid = r_fwd_valid;
    assign wb_o_fwd_addr  = r_fwd_addr;
    assign wb_o_fwd_data  = r_fwd_data;
    assign wb_o_retired   = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_writeback_stage;

    logic        clk;
    logic        rst;
    logic        ce, stall, flush, memtoreg, reg_wr, jal;
    logic [31:0] alu_value, mem_data, pc;
    logic [4:0]  addr_rd;

    logic        o_reg_wr, o_ce, o_fwd_valid;
    logic [4:0]  o_addr_rd, o_fwd_addr;
    logic [31:0] o_data_rd, o_fwd_data, o_retired;

    int n_checks = 0;
    int n_err    = 0;

    writeback_stage dut (
        .wb_clk        (clk),
        .wb_rst        (rst),
        .wb_i_ce       (ce),
        .wb_i_stall    (stall),
        .wb_i_flush    (flush),
        .wb_i_alu_value(alu_value),
        .wb_i_mem_data (mem_data),
        .wb_i_memtoreg (memtoreg),
        .wb_i_reg_wr   (reg_wr),
        .wb_i_jal      (jal),
        .wb_i_pc       (pc),
        .wb_i_addr_rd  (addr_rd),
        .wb_o_reg_wr   (o_reg_wr),
        .wb_o_addr_rd  (o_addr_rd),
        .wb_o_data_rd  (o_data_rd),
        .wb_o_ce       (o_ce),
        .wb_o_fwd_valid(o_fwd_valid),
        .wb_o_fwd_addr (o_fwd_addr),
        .wb_o_fwd_data (o_fwd_data),
        .wb_o_retired  (o_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An instruction held by the stage: whether it is live, and whether it has not yet had
    // its one chance to write and retire.
    typedef struct packed {
        bit          live;
        bit          unspent;
        bit          rw;
        bit          jal;
        bit          m2r;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
        logic [4:0]  rd;
    } instr_t;

    instr_t      m_ins;
    bit          m_fwd_v;
    logic [4:0]  m_fwd_a;
    logic [31:0] m_fwd_d;
    logic [31:0] m_ret;
    logic [31:0] ret_bias;   // offset applied when the bench preloads the DUT counter

    function automatic logic [4:0] exp_addr(input instr_t e);
        return e.jal ? 5'd31 : e.rd;
    endfunction

    function automatic logic [31:0] exp_data(input instr_t e);
        if (e.jal) return e.pc + 32'd4;
        if (e.m2r) return e.mem;
        return e.alu;
    endfunction

    function automatic bit exp_wr(input instr_t e);
        return e.live && e.unspent && (e.rw || e.jal) && (exp_addr(e) != 5'd0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ins   <= '0;
            m_fwd_v <= 1'b0;
            m_fwd_a <= '0;
            m_fwd_d <= '0;
            m_ret   <= '0;
        end else begin
            m_fwd_v <= exp_wr(m_ins);
            if (exp_wr(m_ins)) begin
                m_fwd_a <= exp_addr(m_ins);
                m_fwd_d <= exp_data(m_ins);
            end
            if (m_ins.live && m_ins.unspent) m_ret <= m_ret + 32'd1;
            if (flush) begin
                m_ins.live    <= 1'b0;
                m_ins.unspent <= 1'b0;
            end else if (stall) begin
                m_ins.unspent <= 1'b0;
            end else begin
                m_ins <= '{live: ce, unspent: ce, rw: reg_wr, jal: jal, m2r: memtoreg,
                           alu: alu_value, mem: mem_data, pc: pc, rd: addr_rd};
            end
        end
    end

    // Per-cycle compare, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        check("ce", {31'd0, o_ce}, {31'd0, m_ins.live});
        check("reg_wr", {31'd0, o_reg_wr}, {31'd0, exp_wr(m_ins)});
        if (exp_wr(m_ins)) begin
            check("addr_rd", {27'd0, o_addr_rd}, {27'd0, exp_addr(m_ins)});
            check("data_rd", o_data_rd, exp_data(m_ins));
        end
        check("fwd_valid", {31'd0, o_fwd_valid}, {31'd0, m_fwd_v});
        if (m_fwd_v) begin
            check("fwd_addr", {27'd0, o_fwd_addr}, {27'd0, m_fwd_a});
            check("fwd_data", o_fwd_data, m_fwd_d);
        end
        check("retired", o_retired, m_ret + ret_bias);
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit c, input bit rw, input bit j, input bit m2, input bit st,
                         input bit fl, input logic [31:0] a, input logic [31:0] md,
                         input logic [31:0] p, input logic [4:0] r);
        ce = c; reg_wr = rw; jal = j; memtoreg = m2; stall = st; flush = fl;
        alu_value = a; mem_data = md; pc = p; addr_rd = r;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0, 5'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reg_wr"}, {31'd0, o_reg_wr}, 32'd0);
        check({tag, "_addr_rd"}, {27'd0, o_addr_rd}, 32'd0);
        check({tag, "_data_rd"}, o_data_rd, 32'd0);
        check({tag, "_ce"}, {31'd0, o_ce}, 32'd0);
        check({tag, "_fwd_valid"}, {31'd0, o_fwd_valid}, 32'd0);
        check({tag, "_fwd_addr"}, {27'd0, o_fwd_addr}, 32'd0);
        check({tag, "_fwd_data"}, o_fwd_data, 32'd0);
        check({tag, "_retired"}, o_retired, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        ret_bias = 32'd0;
        idle();
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_release");

        // ALU write to $8 and its bypass window
        drive(1, 1, 0, 0, 0, 0, 32'h1234, 32'h0, 32'h0, 5'd8);
        @(negedge clk); idle();
        check("alu_wr", {31'd0, o_reg_wr}, 32'd1);
        check("alu_addr", {27'd0, o_addr_rd}, 32'd8);
        check("alu_data", o_data_rd, 32'h1234);
        check("alu_ret0", o_retired, 32'd0);
        @(negedge clk);
        check("alu_fwd_v", {31'd0, o_fwd_valid}, 32'd1);
        check("alu_fwd_a", {27'd0, o_fwd_addr}, 32'd8);
        check("alu_fwd_d", o_fwd_data, 32'h1234);
        check("alu_ret1", o_retired, 32'd1);
        @(negedge clk);
        check("alu_fwd_gone", {31'd0, o_fwd_valid}, 32'd0);

        // Load to $9, then the same load to $0
        drive(1, 1, 0, 1, 0, 0, 32'h5555, 32'hDEADBEEF, 32'h0, 5'd9);
        @(negedge clk);
        check("ld_wr", {31'd0, o_reg_wr}, 32'd1);
        check("ld_addr", {27'd0, o_addr_rd}, 32'd9);
        check("ld_data", o_data_rd, 32'hDEADBEEF);
        drive(1, 1, 0, 1, 0, 0, 32'h5555, 32'hDEADBEEF, 32'h0, 5'd0);
        @(negedge clk); idle();
        check("ld_r0_wr", {31'd0, o_reg_wr}, 32'd0);
        @(negedge clk);
        check("ld_ret", o_retired, 32'd3);

        // jal: link value, forced $31, wrap of the link address
        drive(1, 0, 1, 1, 0, 0, 32'h77, 32'h88, 32'h00400010, 5'd3);
        @(negedge clk);
        check("jal_wr", {31'd0, o_reg_wr}, 32'd1);
        check("jal_addr", {27'd0, o_addr_rd}, 32'd31);
        check("jal_data", o_data_rd, 32'h00400014);
        drive(1, 0, 1, 0, 0, 0, 32'h77, 32'h88, 32'hFFFFFFFC, 5'd3);
        @(negedge clk); idle();
        check("jal_wrap_wr", {31'd0, o_reg_wr}, 32'd1);
        check("jal_wrap_data", o_data_rd, 32'h0);
        @(negedge clk);
        check("jal_ret", o_retired, 32'd5);

        // Stall for three cycles after an ALU write to $5, then stall+flush together
        drive(1, 1, 0, 0, 0, 0, 32'h55, 32'h0, 32'h0, 5'd5);
        @(negedge clk);
        check("st_wr_first", {31'd0, o_reg_wr}, 32'd1);
        check("st_addr", {27'd0, o_addr_rd}, 32'd5);
        drive(1, 1, 0, 0, 1, 0, 32'h66, 32'h0, 32'h0, 5'd7);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("st_wr_held", {31'd0, o_reg_wr}, 32'd0);
            check("st_ce_held", {31'd0, o_ce}, 32'd1);
        end
        check("st_ret", o_retired, 32'd6);
        drive(1, 1, 0, 0, 1, 1, 32'h66, 32'h0, 32'h0, 5'd7);
        @(negedge clk); idle();
        check("fl_ce", {31'd0, o_ce}, 32'd0);
        check("fl_wr", {31'd0, o_reg_wr}, 32'd0);
        check("fl_ret", o_retired, 32'd6);

        // Asynchronous reset between edges while an entry is live
        drive(1, 1, 0, 0, 0, 0, 32'hAA, 32'h0, 32'h0, 5'd4);
        @(negedge clk);
        check("pre_rst_wr", {31'd0, o_reg_wr}, 32'd1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive(1, 1, 0, 0, 0, 0, 32'hBB, 32'h0, 32'h0, 5'd12);
        @(negedge clk); idle();
        check("post_rst_wr", {31'd0, o_reg_wr}, 32'd1);
        check("post_rst_addr", {27'd0, o_addr_rd}, 32'd12);
        check("post_rst_data", o_data_rd, 32'hBB);
        @(negedge clk);
        check("post_rst_ret", o_retired, 32'd1);

        // Randomized traffic, with two short reset pulses
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 6) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                  $urandom, $urandom,
                  ($urandom_range(0, 9) == 0) ? 32'hFFFFFFFC : $urandom,
                  ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31)));
            if (i == 700 || i == 1400) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end

        // Counter wrap via a preloaded count
        @(negedge clk); idle();
        @(negedge clk);
        drive(1, 1, 0, 0, 0, 0, 32'h1, 32'h0, 32'h0, 5'd2);
        #1 force dut.r_retired = 32'hFFFFFFFF;
        ret_bias = 32'hFFFFFFFF - m_ret;
        #1 release dut.r_retired;
        @(negedge clk); idle();
        check("wrap_pre", o_retired, 32'hFFFFFFFF);
        @(negedge clk);
        check("wrap_post", o_retired, 32'h0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
